// File: rtl/adder_pkg.sv
// Shared types and defaults for the pipelined add/subtract unit.
// Build option: PIPE_ADDER_SAT_EN clamps negative SUB results to zero.
package adder_pkg;

    typedef enum logic {OP_ADD, OP_SUB} op_e;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_STAGES = 1;

endpackage

// File: rtl/pipe_adder_stage.sv
// One register slice of the adder pipeline: valid bit, result and borrow.
// Loads when enabled, holds otherwise; synchronous reset clears every field.
module pipe_adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             d_valid,
    input  logic [WIDTH:0]   d_sum,
    input  logic             d_borrow,
    output logic             q_valid,
    output logic [WIDTH:0]   q_sum,
    output logic             q_borrow
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid  <= 1'b0;
            q_sum    <= '0;
            q_borrow <= 1'b0;
        end else if (en) begin
            q_valid  <= d_valid;
            q_sum    <= d_sum;
            q_borrow <= d_borrow;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit with valid/ready on both sides and a global stall.
// Build option: PIPE_ADDER_SAT_EN clamps SUB results with a < b to zero (borrow still set).
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             borrow
);

    // Handshake: a transfer happens on a side when its valid and ready are both
    // high at the clock edge. The whole pipe advances together whenever the
    // output is empty or being taken; otherwise every stage holds, so the output
    // stays stable while out_valid && !out_ready. in_ready never looks at in_valid.
    logic           advance;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] res;
    logic           res_borrow;

    logic           v_chain [STAGES+1];
    logic [WIDTH:0] s_chain [STAGES+1];
    logic           b_chain [STAGES+1];

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    always_comb begin
        res        = '0;
        res_borrow = 1'b0;
        if (op == OP_SUB) begin
            res        = a_ext - b_ext;
            res_borrow = (a < b);
`ifdef PIPE_ADDER_SAT_EN
            if (res_borrow) begin
                res = '0;
            end
`endif
        end else begin
            res = a_ext + b_ext;
        end
    end

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign v_chain[0] = in_valid;
    assign s_chain[0] = res;
    assign b_chain[0] = res_borrow;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (advance),
            .d_valid  (v_chain[i]),
            .d_sum    (s_chain[i]),
            .d_borrow (b_chain[i]),
            .q_valid  (v_chain[i+1]),
            .q_sum    (s_chain[i+1]),
            .q_borrow (b_chain[i+1])
        );
    end

    assign out_valid = v_chain[STAGES];
    assign sum       = s_chain[STAGES];
    assign borrow    = b_chain[STAGES];

endmodule
